// File: rtl/rv32_mod_instruction_fetch.sv
// rv32_mod_instruction_fetch: RV32IMC fetch front-end with halfword realignment
//  Issues word-aligned reads, realigns 16-bit-aligned instruction streams and
//  presents one instruction per valid/ready handshake.
//  Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   redirect_valid/pc          load a new PC and flush all fetch state
//   mem_req/addr/ack/rdata/err word read port, request held until ack
//   instr_valid/ready          decoder handshake
//   instruction/instr_pc       presented instruction (compressed zero-extended) and its address
//   instr_fault                bus error on fetch, instruction forced to 0
module rv32_mod_instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);
  typedef enum logic [2:0] {FETCH, FETCH2, OUT, DRAIN, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, addr_n, instr_n, ipc_n, pc_adv;
  logic [15:0] hbuf, hbuf_n, lo, hi;
  logic hbuf_valid, hv_n, valid_n, fault_n, ack, accept;
  // Requests are only visible once reset is released.
  assign mem_req = rst_n && (state == FETCH || state == FETCH2 || state == DRAIN);
  assign ack = mem_req && mem_ack;
  assign accept = instr_valid && instr_ready;
  assign lo = mem_rdata[15:0];
  assign hi = mem_rdata[31:16];
  assign pc_adv = pc + ((instruction[1:0] != 2'b11) ? 32'd2 : 32'd4);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC & ~32'd1;
      hbuf        <= '0;
      hbuf_valid  <= 1'b0;
      mem_addr    <= RESET_PC & ~32'd3;
      instr_valid <= 1'b0;
      instruction <= '0;
      instr_pc    <= RESET_PC & ~32'd1;
      instr_fault <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      hbuf        <= hbuf_n;
      hbuf_valid  <= hv_n;
      mem_addr    <= addr_n;
      instr_valid <= valid_n;
      instruction <= instr_n;
      instr_pc    <= ipc_n;
      instr_fault <= fault_n;
    end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    hbuf_n  = hbuf;
    hv_n    = hbuf_valid;
    addr_n  = mem_addr;
    valid_n = instr_valid;
    instr_n = instruction;
    ipc_n   = instr_pc;
    fault_n = instr_fault;
    if (redirect_valid) begin
      pc_n    = redirect_pc & ~32'd1;
      hv_n    = 1'b0;
      valid_n = 1'b0;
      // An outstanding request must complete on the bus before the new fetch starts.
      if (mem_req && !mem_ack) state_n = DRAIN;
      else begin
        state_n = FETCH;
        addr_n  = redirect_pc & ~32'd3;
      end
    end else begin
      case (state)
        FETCH, FETCH2: if (ack) begin
          valid_n = 1'b1;
          ipc_n   = pc;
          fault_n = mem_err;
          hv_n    = 1'b0;
          state_n = OUT;
          if (mem_err) instr_n = '0;
          else if (state == FETCH2) begin
            instr_n = {lo, hbuf};
            hbuf_n  = hi;
            hv_n    = 1'b1;
          end else if (!pc[1]) begin
            instr_n = (lo[1:0] != 2'b11) ? {16'h0, lo} : mem_rdata;
            hbuf_n  = hi;
            hv_n    = lo[1:0] != 2'b11;
          end else if (hi[1:0] != 2'b11) instr_n = {16'h0, hi};
          else begin
            // Lower half of a straddling 32-bit instruction; fetch the next word.
            valid_n = 1'b0;
            hbuf_n  = hi;
            state_n = FETCH2;
            addr_n  = {pc[31:2] + 30'd1, 2'b00};
          end
        end
        OUT: if (accept) begin
          valid_n = 1'b0;
          if (instr_fault) state_n = HALT;
          else begin
            pc_n = pc_adv;
            if (hbuf_valid && hbuf[1:0] != 2'b11) begin
              valid_n = 1'b1;
              instr_n = {16'h0, hbuf};
              ipc_n   = pc_adv;
              hv_n    = 1'b0;
            end else if (hbuf_valid) begin
              state_n = FETCH2;
              addr_n  = {pc_adv[31:2] + 30'd1, 2'b00};
            end else begin
              state_n = FETCH;
              addr_n  = pc_adv & ~32'd3;
            end
          end
        end
        DRAIN: if (ack) begin
          state_n = FETCH;
          addr_n  = pc & ~32'd3;
        end
        default: ;
      endcase
    end
  end
endmodule
